// File: rtl/inst_sram_if.sv
// Fetch-stage instruction SRAM port: request side (en/we/addr/wdata) and registered read data.
interface inst_sram_if;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_we,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_we,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: 1-cycle read-first word memory with byte-lane writes,
// address-window checking, saturating access counters and sticky error flags.
module inst_sram_resp #(
    parameter logic [31:0] ADDR_BASE  = 32'h1c000000,
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter logic [31:0] OOR_DATA   = 32'h03400000
) (
    input  logic         clk,
    input  logic         reset,
    inst_sram_if.slave   sram,
    input  logic         clr_cnt,
    output logic [31:0]  rd_cnt,
    output logic [31:0]  wr_cnt,
    output logic         oor_err,
    output logic         align_err
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [31:0]           mem_q [Depth];
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic                  oor_err_q, oor_err_d;
    logic                  align_err_q, align_err_d;

    logic [29:0]           off_w;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  is_rd, is_wr;

    // ADDR_BASE is word aligned, so the word offset equals (addr - ADDR_BASE) >> 2.
    assign off_w    = sram.sram_addr[31:2] - ADDR_BASE[31:2];
    assign in_range = (off_w[29:DEPTH_LOG2] == '0);
    assign idx      = off_w[DEPTH_LOG2-1:0];
    assign is_rd    = sram.sram_en && (sram.sram_we == 4'b0000);
    assign is_wr    = sram.sram_en && (sram.sram_we != 4'b0000);

    always_comb begin
        rdata_d     = rdata_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        oor_err_d   = oor_err_q;
        align_err_d = align_err_q;
        if (sram.sram_en) begin
            rdata_d     = in_range ? mem_q[idx] : OOR_DATA;
            oor_err_d   = oor_err_q | ~in_range;
            align_err_d = align_err_q | (sram.sram_addr[1:0] != 2'b00);
        end
        if (is_rd && (rd_cnt_q != 32'hffffffff)) rd_cnt_d = rd_cnt_q + 32'd1;
        if (is_wr && (wr_cnt_q != 32'hffffffff)) wr_cnt_d = wr_cnt_q + 32'd1;
        if (clr_cnt) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q     <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            oor_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            oor_err_q   <= oor_err_d;
            align_err_q <= align_err_d;
        end
    end

    // Contents survive reset; only the write itself is suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && is_wr && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (sram.sram_we[i]) mem_q[idx][8*i +: 8] <= sram.sram_wdata[8*i +: 8];
            end
        end
    end

    assign sram.sram_rdata = rdata_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;
    assign oor_err         = oor_err_q;
    assign align_err       = align_err_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp: directed scenarios plus randomized traffic
// compared against a word-level behavioural model.
module tb_inst_sram_resp;

    localparam logic [31:0] Base   = 32'h1c000000;
    localparam logic [31:0] OorVal = 32'h03400000;
    localparam longint unsigned Words = 64'd65536;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_cnt;
    logic [31:0] rd_cnt, wr_cnt;
    logic        oor_err, align_err;

    inst_sram_if sram_bus ();

    inst_sram_resp dut (
        .clk       (clk),
        .reset     (reset),
        .sram      (sram_bus),
        .clr_cnt   (clr_cnt),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .oor_err   (oor_err),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] mem_m [int];
    logic [31:0] exp_rdata;
    bit          rdata_known = 0;
    logic [31:0] exp_rd = '0, exp_wr = '0;
    logic        exp_oor = 1'b0, exp_align = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle(input bit en, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit clr, input bit rst);
        longint unsigned off, word;
        int              idx;
        bit              in_rng;
        logic [31:0]     w;
        off    = (longint'(addr) - longint'(Base)) & 64'hffffffff;
        word   = off / 4;
        in_rng = word < Words;
        idx    = int'(word % Words);
        if (rst) begin
            exp_rdata = '0; rdata_known = 1;
            exp_rd = '0; exp_wr = '0; exp_oor = 0; exp_align = 0;
            return;
        end
        if (en) begin
            if (!in_rng) begin
                exp_rdata = OorVal; rdata_known = 1; exp_oor = 1;
            end else if (mem_m.exists(idx)) begin
                exp_rdata = mem_m[idx]; rdata_known = 1;
            end else begin
                rdata_known = 0;
            end
            if (addr % 4 != 0) exp_align = 1;
            if (we == 4'h0) begin
                if (exp_rd != 32'hffffffff) exp_rd = exp_rd + 1;
            end else begin
                if (exp_wr != 32'hffffffff) exp_wr = exp_wr + 1;
                if (in_rng) begin
                    if (mem_m.exists(idx) || we == 4'hf) begin
                        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (we[b]) w[8*b +: 8] = wdata[8*b +: 8];
                        mem_m[idx] = w;
                    end
                end
            end
        end
        if (clr) begin
            exp_rd = '0; exp_wr = '0;
        end
    endtask

    // Apply one cycle of stimulus, advance past the edge, update the model and compare.
    task automatic cyc(input bit en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit clr, input bit rst);
        sram_bus.sram_en    = en;
        sram_bus.sram_we    = we;
        sram_bus.sram_addr  = addr;
        sram_bus.sram_wdata = wdata;
        clr_cnt             = clr;
        reset               = rst;
        @(posedge clk);
        #1;
        model_cycle(en, we, addr, wdata, clr, rst);
        check_eq("rd_cnt", rd_cnt, exp_rd);
        check_eq("wr_cnt", wr_cnt, exp_wr);
        check_eq("oor_err", {31'b0, oor_err}, {31'b0, exp_oor});
        check_eq("align_err", {31'b0, align_err}, {31'b0, exp_align});
        if (rdata_known) check_eq("rdata", sram_bus.sram_rdata, exp_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        bit          en, clr, rst;
        int          pick;

        reset = 1'b1; clr_cnt = 1'b0;
        sram_bus.sram_en = 0; sram_bus.sram_we = 0;
        sram_bus.sram_addr = 0; sram_bus.sram_wdata = 0;

        // Preload through the port, then reset again (memory must survive).
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 1);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 1);
        cyc(1, 4'hf, Base,            32'h02800c0c, 0, 0);
        cyc(1, 4'hf, Base + 32'd4,    32'h11223344, 0, 0);
        for (int i = 2; i < 8; i++) cyc(1, 4'hf, Base + 32'(4 * i), $urandom, 0, 0);
        for (int i = 65532; i < 65536; i++) cyc(1, 4'hf, Base + 32'(4 * i), $urandom, 0, 0);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 1);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 1);
        check_eq("reset_rdata", sram_bus.sram_rdata, 32'h0);

        cyc(1, 4'h0, Base, 32'h0, 0, 0);
        check_eq("first_fetch", sram_bus.sram_rdata, 32'h02800c0c);
        check_eq("first_rd_cnt", rd_cnt, 32'd1);

        cyc(1, 4'b0011, Base + 32'd4, 32'haabbccdd, 0, 0);
        check_eq("write_read_first", sram_bus.sram_rdata, 32'h11223344);
        cyc(1, 4'h0, Base + 32'd4, 32'h0, 0, 0);
        check_eq("byte_merge", sram_bus.sram_rdata, 32'h1122ccdd);
        check_eq("wr_cnt_one", wr_cnt, 32'd1);

        cyc(1, 4'h0, Base, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'h0, 32'h0, 32'h0, 0, 0);
            check_eq("idle_hold", sram_bus.sram_rdata, 32'h02800c0c);
        end

        cyc(1, 4'h0, 32'h1bfffffc, 32'h0, 0, 0);
        check_eq("below_base_data", sram_bus.sram_rdata, OorVal);
        check_eq("below_base_flag", {31'b0, oor_err}, 32'd1);
        idle(10);
        check_eq("oor_sticky", {31'b0, oor_err}, 32'd1);

        cyc(1, 4'hf, Base, 32'h0, 0, 1);
        check_eq("rst_rdata", sram_bus.sram_rdata, 32'h0);
        check_eq("rst_rd_cnt", rd_cnt, 32'h0);
        check_eq("rst_oor", {31'b0, oor_err}, 32'h0);
        cyc(1, 4'h0, Base, 32'h0, 0, 0);
        check_eq("rst_write_dropped", sram_bus.sram_rdata, 32'h02800c0c);

        cyc(1, 4'h0, Base + 32'd2, 32'h0, 0, 0);
        check_eq("misalign_flag", {31'b0, align_err}, 32'd1);
        check_eq("misalign_data", sram_bus.sram_rdata, 32'h02800c0c);
        cyc(1, 4'h0, Base, 32'h0, 1, 0);
        check_eq("clr_wins", rd_cnt, 32'h0);

        // Window edge: last word in range, first word past it.
        cyc(1, 4'h0, Base + 32'(4 * 65535), 32'h0, 0, 0);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 1);
        cyc(1, 4'hf, Base + 32'(4 * 65536), 32'h12345678, 0, 0);
        check_eq("past_top_data", sram_bus.sram_rdata, OorVal);

        for (int n = 0; n < 800; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 45)      a = Base + 32'(4 * $urandom_range(0, 7));
            else if (pick < 75) a = Base + 32'(4 * $urandom_range(65532, 65535));
            else if (pick < 88) a = Base - 32'(4 * $urandom_range(1, 1000));
            else                a = Base + 32'(4 * $urandom_range(65536, 70000));
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            en  = ($urandom_range(0, 9) < 7);
            we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cyc(en, we, a, $urandom, clr, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
